// File: rtl/expr_recognizer_pkg.sv
// Shared types and ASCII constants for the streaming arithmetic-expression recognizer.
package expr_recognizer_pkg;

    typedef enum logic [1:0] {
        EXPECT,
        NUM,
        CLOSE,
        DEAD
    } state_t;

    typedef enum logic [2:0] {
        CLS_DIGIT,
        CLS_OP,
        CLS_LP,
        CLS_RP,
        CLS_SP,
        CLS_ILLEGAL
    } char_class_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_LP    = 8'h28;
    localparam logic [7:0] ASCII_RP    = 8'h29;
    localparam logic [7:0] ASCII_SP    = 8'h20;

endpackage

// File: rtl/expr_recognizer_char_class.sv
// Combinational byte classifier; disabled features fall through to ILLEGAL.
module expr_char_class
    import expr_recognizer_pkg::*;
#(
    parameter int ALLOW_SUB   = 1,
    parameter int ALLOW_PAREN = 1
) (
    input  logic [7:0]  in,
    output char_class_t cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        if (in >= ASCII_0 && in <= ASCII_9) begin
            cls = CLS_DIGIT;
        end else if (in == ASCII_PLUS || in == ASCII_STAR) begin
            cls = CLS_OP;
        end else if (in == ASCII_MINUS && ALLOW_SUB != 0) begin
            cls = CLS_OP;
        end else if (in == ASCII_LP && ALLOW_PAREN != 0) begin
            cls = CLS_LP;
        end else if (in == ASCII_RP && ALLOW_PAREN != 0) begin
            cls = CLS_RP;
        end else if (in == ASCII_SP) begin
            cls = CLS_SP;
        end
    end

endmodule

// File: rtl/expr_recognizer.sv
// Byte-serial recognizer for infix expressions of decimal operands, + * - and parentheses.
// out/err/depth/nterms all come from flops and reflect bytes consumed up to the previous edge.
module expr_recognizer
    import expr_recognizer_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int MAX_DEPTH   = 7,
    parameter int ALLOW_SUB   = 1,
    parameter int ALLOW_PAREN = 1
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           in_valid,
    input  logic [7:0]                     in,
    output logic                           out,
    output logic                           err,
    output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
    output logic [7:0]                     nterms
);

    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX  = DW'(MAX_DEPTH);
    localparam logic [3:0]    DIGITS_MAX = 4'(MAX_DIGITS);

    char_class_t    cls;
    state_t         state, state_nx;
    logic [3:0]     dcnt, dcnt_nx;
    logic [DW-1:0]  depth_nx;
    logic [7:0]     nterms_nx;
    logic           gap, gap_nx;
    logic           out_nx;

    expr_char_class #(
        .ALLOW_SUB   (ALLOW_SUB),
        .ALLOW_PAREN (ALLOW_PAREN)
    ) u_class (
        .in  (in),
        .cls (cls)
    );

    // gap remembers a space seen inside an operand, so a later digit cannot extend it
    always_comb begin
        state_nx  = state;
        dcnt_nx   = dcnt;
        depth_nx  = depth;
        nterms_nx = nterms;
        gap_nx    = gap;
        if (in_valid && state != DEAD && cls == CLS_SP) begin
            if (state == NUM) gap_nx = 1'b1;
        end else if (in_valid && state != DEAD) begin
            gap_nx   = 1'b0;
            state_nx = DEAD;
            unique case (state)
                EXPECT: begin
                    if (cls == CLS_DIGIT) begin
                        state_nx  = NUM;
                        dcnt_nx   = 4'd1;
                        nterms_nx = (nterms == 8'hFF) ? nterms : nterms + 8'd1;
                    end else if (cls == CLS_LP && depth < DEPTH_MAX) begin
                        state_nx = EXPECT;
                        depth_nx = depth + DW'(1);
                    end
                end
                NUM: begin
                    if (cls == CLS_DIGIT && !gap && dcnt < DIGITS_MAX) begin
                        state_nx = NUM;
                        dcnt_nx  = dcnt + 4'd1;
                    end else if (cls == CLS_OP) begin
                        state_nx = EXPECT;
                    end else if (cls == CLS_RP && depth != '0) begin
                        state_nx = CLOSE;
                        depth_nx = depth - DW'(1);
                    end
                end
                CLOSE: begin
                    if (cls == CLS_OP) begin
                        state_nx = EXPECT;
                    end else if (cls == CLS_RP && depth != '0) begin
                        state_nx = CLOSE;
                        depth_nx = depth - DW'(1);
                    end
                end
                default: state_nx = DEAD;
            endcase
        end
        out_nx = (state_nx == NUM || state_nx == CLOSE) && depth_nx == '0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= EXPECT;
            dcnt   <= 4'd0;
            depth  <= '0;
            nterms <= 8'd0;
            gap    <= 1'b0;
            out    <= 1'b0;
        end else begin
            state  <= state_nx;
            dcnt   <= dcnt_nx;
            depth  <= depth_nx;
            nterms <= nterms_nx;
            gap    <= gap_nx;
            out    <= out_nx;
        end
    end

    assign err = (state == DEAD);

endmodule

// File: tb/tb_expr_recognizer.sv
// Self-checking bench: a prefix-rescanning grammar model checked every cycle on two
// differently configured instances, plus hand-computed directed expectations.
`timescale 1ns/100ps
module tb_expr_recognizer;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in = 8'h00;

    logic       out_a, err_a;
    logic [2:0] depth_a;
    logic [7:0] nterms_a;
    logic       out_b, err_b;
    logic [1:0] depth_b;
    logic [7:0] nterms_b;

    int checks = 0;
    int failures = 0;
    logic [7:0] hist[$];

    typedef struct {
        bit out;
        bit err;
        int depth;
        int nterms;
    } expect_t;

    expect_t ea, eb;

    expr_recognizer #(.MAX_DIGITS(4), .MAX_DEPTH(7), .ALLOW_SUB(1), .ALLOW_PAREN(1)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_a), .err(err_a), .depth(depth_a), .nterms(nterms_a)
    );

    expr_recognizer #(.MAX_DIGITS(2), .MAX_DEPTH(3), .ALLOW_SUB(0), .ALLOW_PAREN(0)) dut_ns (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_b), .err(err_b), .depth(depth_b), .nterms(nterms_b)
    );

    always #5 clk = ~clk;

    // Rescan the whole accepted stream from scratch and judge it against the grammar.
    function automatic expect_t modelEval(input logic [7:0] h[$], input int maxDigits,
                                          input int maxDepth, input bit allowSub,
                                          input bit allowParen);
        expect_t r;
        logic [7:0] c;
        int open = 0, terms = 0, len = 0;
        bit needOperand = 1'b1, inNumber = 1'b0, spaced = 1'b0, bad = 1'b0;
        foreach (h[i]) begin
            c = h[i];
            if (c == " ") begin
                if (inNumber) spaced = 1'b1;
                continue;
            end
            if (c >= "0" && c <= "9") begin
                if (needOperand) begin
                    terms = (terms < 255) ? terms + 1 : 255;
                    len = 1;
                    needOperand = 1'b0;
                    inNumber = 1'b1;
                    spaced = 1'b0;
                end else if (inNumber && !spaced && len < maxDigits) begin
                    len++;
                end else begin
                    bad = 1'b1;
                end
            end else if (c == "+" || c == "*" || (c == "-" && allowSub)) begin
                if (needOperand) bad = 1'b1;
                else begin
                    needOperand = 1'b1;
                    inNumber = 1'b0;
                end
            end else if (c == "(" && allowParen) begin
                if (needOperand && open < maxDepth) open++;
                else bad = 1'b1;
            end else if (c == ")" && allowParen) begin
                if (!needOperand && open > 0) begin
                    open--;
                    inNumber = 1'b0;
                end else bad = 1'b1;
            end else begin
                bad = 1'b1;
            end
            if (bad) break;
        end
        r.out = !bad && !needOperand && open == 0;
        r.err = bad;
        r.depth = open;
        r.nterms = terms;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    always @(posedge clk) begin
        if (!clr && in_valid) hist.push_back(in);
    end

    always @(posedge clr) hist.delete();

    always @(posedge clk) begin
        #2;
        ea = modelEval(hist, 4, 7, 1'b1, 1'b1);
        eb = modelEval(hist, 2, 3, 1'b0, 1'b0);
        checkOutput("model A out", int'(out_a), int'(ea.out));
        checkOutput("model A err", int'(err_a), int'(ea.err));
        checkOutput("model A depth", int'(depth_a), ea.depth);
        checkOutput("model A nterms", int'(nterms_a), ea.nterms);
        checkOutput("model B out", int'(out_b), int'(eb.out));
        checkOutput("model B err", int'(err_b), int'(eb.err));
        checkOutput("model B depth", int'(depth_b), eb.depth);
        checkOutput("model B nterms", int'(nterms_b), eb.nterms);
    end

    task automatic applyStimulus(input logic [7:0] c);
        @(negedge clk);
        in = c;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        in = "9";
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        @(negedge clk);
        clr = 1'b1;
        in = "(";
        in_valid = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
    endtask

    // Expectation strings hold one character per byte; empty strings skip that output.
    task automatic runString(input string name, input string s, input string expOut,
                             input string expErr, input string expDepth);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i]);
            if (expOut.len() > i)
                checkOutput($sformatf("%s out[%0d]", name, i), int'(out_a), int'(expOut[i] == "1"));
            if (expErr.len() > i)
                checkOutput($sformatf("%s err[%0d]", name, i), int'(err_a), int'(expErr[i] == "1"));
            if (expDepth.len() > i)
                checkOutput($sformatf("%s depth[%0d]", name, i), int'(depth_a), int'(expDepth[i]) - 48);
        end
    endtask

    initial begin
        string s;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("reset out", int'(out_a), 0);
        checkOutput("reset err", int'(err_a), 0);
        checkOutput("reset depth", int'(depth_a), 0);
        checkOutput("reset nterms", int'(nterms_a), 0);

        runString("arith", "12+3*45", "1101011", "0000000", "");
        checkOutput("arith nterms", int'(nterms_a), 3);

        doReset();
        runString("paren", "(1+(2))", "0000001", "0000000", "1112210");

        doReset();
        runString("digits", "12345+1", "1111000", "0000111", "");

        doReset();
        s = "1-2";
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i]);
            checkOutput($sformatf("nosub err[%0d]", i), int'(err_b), (i > 0) ? 1 : 0);
        end
        checkOutput("sub final out", int'(out_a), 1);

        doReset();
        applyStimulus("1");
        idleCycles(2);
        applyStimulus(" ");
        checkOutput("space holds out", int'(out_a), 1);
        idleCycles(3);
        applyStimulus("+");
        idleCycles(1);
        applyStimulus(" ");
        applyStimulus("2");
        checkOutput("gaps final out", int'(out_a), 1);
        checkOutput("gaps final err", int'(err_a), 0);

        doReset();
        runString("split", "1 2", "110", "001", "");

        doReset();
        runString("nest", "((((((((", "00000000", "00000001", "12345677");

        doReset();
        runString("rp0", "1)", "10", "01", "00");

        doReset();
        repeat (256) begin
            applyStimulus("1");
            applyStimulus("+");
        end
        applyStimulus("1");
        checkOutput("sat nterms", int'(nterms_a), 255);
        checkOutput("sat out", int'(out_a), 1);

        doReset();
        runString("preclr", "(1+", "000", "000", "111");
        #1;
        clr = 1'b1;
        #1;
        checkOutput("async clr out", int'(out_a), 0);
        checkOutput("async clr err", int'(err_a), 0);
        checkOutput("async clr depth", int'(depth_a), 0);
        checkOutput("async clr nterms", int'(nterms_a), 0);
        clr = 1'b0;
        applyStimulus("7");
        checkOutput("post clr out", int'(out_a), 1);
        checkOutput("post clr depth", int'(depth_a), 0);
        checkOutput("post clr nterms", int'(nterms_a), 1);

        idleCycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/expr_recognizer.md
EXPR_RECOGNIZER -- requirements
Module: expr_recognizer

Interface
REQ-001 Parameter MAX_DIGITS, default 4: maximum decimal digits per operand, range 1..15.
REQ-002 Parameter MAX_DEPTH, default 7: maximum parenthesis nesting depth, range 1..255.
REQ-003 Parameter ALLOW_SUB, default 1: 1 makes '-' (0x2D) an operator; 0 makes it an illegal character.
REQ-004 Parameter ALLOW_PAREN, default 1: 1 enables '(' and ')'; 0 makes both illegal characters.
REQ-005 Port clk, input, 1: the single clock; all state updates on posedge.
REQ-006 Port clr, input, 1: reset, asynchronous and active-high.
REQ-007 Port in_valid, input, 1: when high, the byte on in is consumed at this posedge.
REQ-008 Port in, input, 8: ASCII character.
REQ-009 Port out, output, 1: high when all bytes consumed so far form a complete valid expression.
REQ-010 Port err, output, 1: sticky error flag; high once the stream can no longer become valid.
REQ-011 Port depth, output, $clog2(MAX_DEPTH+1): current count of open parentheses.
REQ-012 Port nterms, output, 8: count of operands started, saturating at 255.

Function
REQ-013 Character classes SHALL be: DIGIT '0'..'9'; OP '+', '*', and '-' when ALLOW_SUB=1; LP '('; RP ')'; SP 0x20; all others ILLEGAL.
REQ-014 The FSM SHALL have states EXPECT (operand expected), NUM (inside operand), CLOSE (after ')') and DEAD.
REQ-015 In EXPECT: DIGIT -> NUM, digit count := 1, nterms +1; LP with depth<MAX_DEPTH -> EXPECT, depth +1; all other non-SP classes -> DEAD.
REQ-016 In NUM: DIGIT with digit count<MAX_DIGITS -> NUM, digit count +1; DIGIT at MAX_DIGITS -> DEAD; OP -> EXPECT; RP with depth>0 -> CLOSE, depth -1; all other non-SP classes -> DEAD.
REQ-017 In CLOSE: OP -> EXPECT; RP with depth>0 -> CLOSE, depth -1; all other non-SP classes -> DEAD.
REQ-018 DEAD SHALL be absorbing until clr.
REQ-019 LP at depth==MAX_DEPTH and RP at depth==0 SHALL go to DEAD.
REQ-020 An SP byte in a non-DEAD state SHALL leave state, depth, digit count and outputs unchanged.
REQ-021 An SP byte inside NUM SHALL end the operand: a following DIGIT goes to DEAD, not NUM.
REQ-022 With ALLOW_PAREN=0, LP and RP SHALL be treated as ILLEGAL.
REQ-023 Cycles with in_valid=0 SHALL change no state, counter or output.
REQ-024 out SHALL be registered: high in the cycle after accepting a byte that leaves the FSM in NUM or CLOSE with depth==0; otherwise low.
REQ-025 err SHALL be registered and high exactly when the state is DEAD; out SHALL be 0 whenever err=1.
REQ-026 Latency SHALL be 1 clock from the consuming posedge to the updated out, err, depth and nterms.
REQ-027 nterms SHALL hold at 255 once it reaches 255.
REQ-028 depth SHALL never exceed MAX_DEPTH or wrap below 0.

Reset
REQ-029 clr=1 SHALL force the following immediately, independent of clk: state=EXPECT, digit count=0, depth=0, nterms=0, out=0, err=0.
REQ-030 Bytes presented while clr=1 SHALL be ignored.
REQ-031 The first byte consumed SHALL be the one at the first posedge after clr falls.
REQ-032 clr asserted mid-expression SHALL discard all partial state.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the character-class enum and the ASCII constants: '0', '9', '+', '-', '*', '(', ')', space.
REQ-034 A combinational sub-module expr_char_class SHALL map in plus ALLOW_SUB/ALLOW_PAREN to a class code.
REQ-035 expr_recognizer SHALL instantiate expr_char_class and contain the FSM and counters.

Verification
REQ-036 Stream "12+3*45", one byte per cycle -> out = 1,1,0,1,0,1,1; err=0; nterms=3.
REQ-037 Stream "(1+(2))" -> depth = 1,1,1,2,2,1,0; out=1 only after the final ')'; err=0.
REQ-038 Stream "12345" with MAX_DIGITS=4 -> out=1 for bytes 1-4, then err=1 and out=0 from byte 5 onward; a subsequent "+1" keeps err=1.
REQ-039 Stream "1-2" with ALLOW_SUB=0 -> err=1 after '-'; the same stream with ALLOW_SUB=1 -> final out=1.
REQ-040 Stream "1 + 2" with in_valid gaps -> final out=1; "1 2" -> err=1 after the second digit.
REQ-041 Send "(1+" then pulse clr between clock edges -> all outputs 0 immediately; then "7" -> out=1, depth=0, nterms=1.
